serial_subtractor: RTL

// Multi-cycle, bit-serial unsigned/two's-complement subtractor for the datapath: diff = a - b.

---
 rtl/serial_subtractor.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, one bit per clock, LSB first, through a
// single full-subtractor cell. Start/done handshake; results held until the
// next accepted start.
// Optional feature macro: ADD_MODE_EN adds a `sub` input. sub=0 selects a + b
// through the same cell, with carry replacing borrow.
module serial_subtractor #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef ADD_MODE_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             overflow
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Counter is WIDTH bits wide so it can never wrap inside RUN.
   localparam logic [WIDTH-1:0] LAST_CNT = WIDTH'(WIDTH - 1);
   localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

   // One serial cell. Returns {borrow/carry out, result bit}.
   // Subtract: d = a^b^br, br' = (~a & b) | (~(a^b) & br).
   // Add:      d = a^b^c,  c'  = majority(a, b, c).
   function automatic logic [1:0] serial_cell(input logic ai, input logic bi,
                                              input logic cin, input logic is_sub);
      logic d;
      logic cout;
      d = ai ^ bi ^ cin;
      if (is_sub) begin
         cout = (~ai & bi) | (~(ai ^ bi) & cin);
      end else begin
         cout = (ai & bi) | (ai & cin) | (bi & cin);
      end
      return {cout, d};
   endfunction

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             cb_q, cb_d;
   logic             borrow_q, borrow_d;
   logic             overflow_q, overflow_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             sub_mode_s;
   logic             sub_capture_s;
   logic [1:0]       cell_s;

`ifdef ADD_MODE_EN
   logic sub_q, sub_d;
   assign sub_mode_s    = sub_q;
   assign sub_capture_s = sub;
`else
   assign sub_mode_s    = 1'b1;
   assign sub_capture_s = 1'b1;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: IDLE -> RUN on start, RUN -> DONE after the MSB, DONE -> IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            if (cnt_q == LAST_CNT) begin
               state_d = S_DONE;
            end else begin
               state_d = S_RUN;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath: capture operands on start, run the serial cell during RUN.
   always_comb begin
      a_d        = a_q;
      b_d        = b_q;
      diff_d     = diff_q;
      cnt_d      = cnt_q;
      cb_d       = cb_q;
      borrow_d   = borrow_q;
      overflow_d = overflow_q;
`ifdef ADD_MODE_EN
      sub_d      = sub_q;
`endif
      cell_s     = serial_cell(a_q[0], b_q[0], cb_q, sub_mode_s);
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d   = a;
               b_d   = b;
               cb_d  = 1'b0;
               cnt_d = {WIDTH{1'b0}};
`ifdef ADD_MODE_EN
               sub_d = sub_capture_s;
`endif
            end else begin
               cnt_d = cnt_q;
            end
         end
         S_RUN: begin
            a_d    = {1'b0, a_q[WIDTH-1:1]};
            b_d    = {1'b0, b_q[WIDTH-1:1]};
            cb_d   = cell_s[1];
            diff_d = {cell_s[0], diff_q[WIDTH-1:1]};
            cnt_d  = cnt_q + CNT_ONE;
            if (cnt_q == LAST_CNT) begin
               // Here a_q[0]/b_q[0] are the operand sign bits and cell_s[0] the result sign.
               borrow_d = cell_s[1];
               if (sub_mode_s) begin
                  overflow_d = (a_q[0] != b_q[0]) && (cell_s[0] != a_q[0]);
               end else begin
                  overflow_d = (a_q[0] == b_q[0]) && (cell_s[0] != a_q[0]);
               end
            end else begin
               borrow_d   = borrow_q;
               overflow_d = overflow_q;
            end
         end
         S_DONE:  cnt_d = cnt_q;
         default: cnt_d = cnt_q;
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   // Datapath and handshake registers; reset clears everything, aborting any operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q        <= {WIDTH{1'b0}};
         b_q        <= {WIDTH{1'b0}};
         diff_q     <= {WIDTH{1'b0}};
         cnt_q      <= {WIDTH{1'b0}};
         cb_q       <= 1'b0;
         borrow_q   <= 1'b0;
         overflow_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef ADD_MODE_EN
         sub_q      <= 1'b1;
`endif
      end else begin
         a_q        <= a_d;
         b_q        <= b_d;
         diff_q     <= diff_d;
         cnt_q      <= cnt_d;
         cb_q       <= cb_d;
         borrow_q   <= borrow_d;
         overflow_q <= overflow_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
`ifdef ADD_MODE_EN
         sub_q      <= sub_d;
`endif
      end
   end

   // Outputs come straight from registers.
   always_comb begin
      busy     = busy_q;
      done     = done_q;
      diff     = diff_q;
      borrow   = borrow_q;
      overflow = overflow_q;
   end

endmodule
